// File: rtl/calib_sequencer_pkg.sv
// Shared FSM encoding and VGA frame-timing widths for the calibration sequencer,
// the centre-of-mass logic and the cue tracker.
package calib_sequencer_pkg;

    localparam int HC_W = 11;   // hcount width
    localparam int VC_W = 10;   // vcount width
    localparam int X_W  = 11;   // zone x coordinate width
    localparam int Y_W  = 10;   // zone y coordinate width

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_COLLECT = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    function automatic logic [X_W-1:0] abs_diff(input logic [X_W-1:0] a,
                                                input logic [X_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic is_frame_start(input logic [HC_W-1:0] hc,
                                            input logic [VC_W-1:0] vc);
        return (hc == '0) && (vc == '0);
    endfunction

    function automatic logic is_line_start(input logic [HC_W-1:0] hc,
                                           input logic [VC_W-1:0] vc,
                                           input logic [VC_W-1:0] line);
        return (hc == '0) && (vc == line);
    endfunction

endpackage

// File: rtl/calib_sequencer_zone_extents.sv
// Combinational zone geometry: four {left,right}/{top,bottom} boxes in, four
// centres and the min/max centre per axis out (ties keep the lowest zone index).
module calib_sequencer_zone_extents
    import calib_sequencer_pkg::*;
(
    input  logic [3:0][2*X_W-1:0] i_hor,
    input  logic [3:0][2*Y_W-1:0] i_vert,
    output logic [3:0][X_W-1:0]   o_cx,
    output logic [3:0][Y_W-1:0]   o_cy,
    output logic [X_W-1:0]        o_x_min,
    output logic [X_W-1:0]        o_x_max,
    output logic [Y_W-1:0]        o_y_min,
    output logic [Y_W-1:0]        o_y_max
);

    logic [X_W:0] w_sum_x [4];
    logic [Y_W:0] w_sum_y [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            // One extra bit on the sum so (l+r) never wraps before the halving.
            w_sum_x[i] = {1'b0, i_hor[i][2*X_W-1:X_W]}  + {1'b0, i_hor[i][X_W-1:0]};
            w_sum_y[i] = {1'b0, i_vert[i][2*Y_W-1:Y_W]} + {1'b0, i_vert[i][Y_W-1:0]};
            o_cx[i]    = w_sum_x[i][X_W:1];
            o_cy[i]    = w_sum_y[i][Y_W:1];
        end
    end

    always_comb begin
        o_x_min = o_cx[0];
        o_x_max = o_cx[0];
        o_y_min = o_cy[0];
        o_y_max = o_cy[0];
        for (int i = 1; i < 4; i++) begin
            if (o_cx[i] < o_x_min) o_x_min = o_cx[i];
            if (o_cx[i] > o_x_max) o_x_max = o_cx[i];
            if (o_cy[i] < o_y_min) o_y_min = o_cy[i];
            if (o_cy[i] > o_y_max) o_y_max = o_cy[i];
        end
    end

endmodule

// File: rtl/calib_sequencer.sv
// Calibration sequencer for the four-zone IR tracker: per-frame zone reset pulse,
// frame-to-frame stability check of the four markers, and table-extent latching.
module calib_sequencer
    import calib_sequencer_pkg::*;
#(
    parameter int RESET_LEN     = 10,
    parameter int SAMPLE_V      = 600,
    parameter int TOL           = 4,
    parameter int STABLE_FRAMES = 8,
    parameter int MAX_FRAMES    = 120
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [HC_W-1:0] hcount,
    input  logic [VC_W-1:0] vcount,
    input  logic [21:0]     hor1,
    input  logic [21:0]     hor2,
    input  logic [21:0]     hor3,
    input  logic [21:0]     hor4,
    input  logic [19:0]     vert1,
    input  logic [19:0]     vert2,
    input  logic [19:0]     vert3,
    input  logic [19:0]     vert4,
    input  logic [3:0]      zone_found,
    output logic            zone_reset,
    output logic            calibrated,
    output logic            cal_fail,
    output logic            busy,
    output logic [X_W-1:0]  xo,
    output logic [X_W-1:0]  xf,
    output logic [Y_W-1:0]  yo,
    output logic [Y_W-1:0]  yf,
    output logic [3:0]      stable_cnt
);

    localparam int                FC_W       = $clog2(MAX_FRAMES + 1);
    localparam int                ZR_W       = $clog2(RESET_LEN + 1);
    localparam logic [FC_W-1:0]   FRAME_LIM  = FC_W'(MAX_FRAMES);
    localparam logic [3:0]        STABLE_LIM = 4'(STABLE_FRAMES);
    localparam logic [ZR_W-1:0]   ZR_LEN     = ZR_W'(RESET_LEN);
    localparam logic [X_W-1:0]    TOL_X      = X_W'(TOL);
    localparam logic [VC_W-1:0]   SAMPLE_LN  = VC_W'(SAMPLE_V);

    state_t                  r_state;
    state_t                  w_next_state;

    logic [ZR_W-1:0]         r_zr_cnt;
    logic [3:0][2*X_W-1:0]   r_hor;
    logic [3:0][2*Y_W-1:0]   r_vert;
    logic [3:0][X_W-1:0]     r_prev_cx;
    logic [3:0][Y_W-1:0]     r_prev_cy;
    logic                    r_first;
    logic [3:0]              r_stable_cnt;
    logic [FC_W-1:0]         r_frame_cnt;
    logic [X_W-1:0]          r_xo;
    logic [X_W-1:0]          r_xf;
    logic [Y_W-1:0]          r_yo;
    logic [Y_W-1:0]          r_yf;

    logic                    w_frame_start;
    logic                    w_sample_pt;
    logic [3:0][X_W-1:0]     w_cx;
    logic [3:0][Y_W-1:0]     w_cy;
    logic [X_W-1:0]          w_x_min;
    logic [X_W-1:0]          w_x_max;
    logic [Y_W-1:0]          w_y_min;
    logic [Y_W-1:0]          w_y_max;
    logic                    w_within;
    logic                    w_stable;
    logic [3:0]              w_stable_next;
    logic [FC_W-1:0]         w_frame_next;

    assign w_frame_start = is_frame_start(hcount, vcount);
    assign w_sample_pt   = is_line_start(hcount, vcount, SAMPLE_LN);

    calib_sequencer_zone_extents u_zone_extents (
        .i_hor   (r_hor),
        .i_vert  (r_vert),
        .o_cx    (w_cx),
        .o_cy    (w_cy),
        .o_x_min (w_x_min),
        .o_x_max (w_x_max),
        .o_y_min (w_y_min),
        .o_y_max (w_y_max)
    );

    // Every centre must stay within TOL of the previous frame, inclusive.
    always_comb begin
        w_within = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (abs_diff(w_cx[i], r_prev_cx[i]) > TOL_X)
                w_within = 1'b0;
            if (abs_diff({1'b0, w_cy[i]}, {1'b0, r_prev_cy[i]}) > TOL_X)
                w_within = 1'b0;
        end
    end

    assign w_stable      = (zone_found == 4'b1111) && !r_first && w_within;
    assign w_stable_next = w_stable ? (r_stable_cnt + 4'd1) : 4'd0;
    assign w_frame_next  = r_frame_cnt + 1'b1;

    // The zone pulse free-runs off the raster so tracking keeps working in IDLE/DONE.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state, so every flop
        // samples the pre-edge values regardless of block ordering.
        if (!reset_n)
            r_zr_cnt <= '0;
        else if (w_frame_start)
            r_zr_cnt <= ZR_LEN;
        else if (r_zr_cnt != '0)
            r_zr_cnt <= r_zr_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch forms.
        w_next_state = r_state;
        case (r_state)
            ST_ARM:     if (w_frame_start) w_next_state = ST_COLLECT;
            ST_COLLECT: if (w_sample_pt)   w_next_state = ST_CHECK;
            ST_CHECK: begin
                if (w_stable_next == STABLE_LIM)
                    w_next_state = ST_DONE;
                else if (w_frame_next == FRAME_LIM)
                    w_next_state = ST_FAIL;
                else
                    w_next_state = ST_COLLECT;
            end
            default: w_next_state = r_state;
        endcase
        if (start)
            w_next_state = ST_ARM;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the bound snapshot is a handful of flops rather than a RAM,
            // so it is reset with everything else and never shows X downstream.
            r_hor        <= '0;
            r_vert       <= '0;
            r_prev_cx    <= '0;
            r_prev_cy    <= '0;
            r_first      <= 1'b1;
            r_stable_cnt <= '0;
            r_frame_cnt  <= '0;
            r_xo         <= '0;
            r_xf         <= '0;
            r_yo         <= '0;
            r_yf         <= '0;
        end else if (start) begin
            r_stable_cnt <= '0;
        end else begin
            case (r_state)
                ST_ARM: begin
                    r_stable_cnt <= '0;
                    r_frame_cnt  <= '0;
                    r_first      <= 1'b1;
                end
                ST_COLLECT: begin
                    if (w_sample_pt) begin
                        r_hor  <= {hor4, hor3, hor2, hor1};
                        r_vert <= {vert4, vert3, vert2, vert1};
                    end
                end
                ST_CHECK: begin
                    r_frame_cnt  <= w_frame_next;
                    r_stable_cnt <= w_stable_next;
                    r_prev_cx    <= w_cx;
                    r_prev_cy    <= w_cy;
                    r_first      <= 1'b0;
                    // Extents are only published on success; FAIL keeps the old table.
                    if (w_stable_next == STABLE_LIM) begin
                        r_xo <= w_x_min;
                        r_xf <= w_x_max;
                        r_yo <= w_y_min;
                        r_yf <= w_y_max;
                    end
                end
                default: ;
            endcase
        end
    end

    assign zone_reset = (r_zr_cnt != '0);
    assign calibrated = (r_state == ST_DONE);
    assign cal_fail   = (r_state == ST_FAIL);
    assign busy       = (r_state == ST_ARM) || (r_state == ST_COLLECT) ||
                        (r_state == ST_CHECK);
    assign stable_cnt = r_stable_cnt;
    assign xo         = r_xo;
    assign xf         = r_xf;
    assign yo         = r_yo;
    assign yf         = r_yf;

endmodule
